quad_decoder: RTL

//  Parametrised quadrature (A/B) rotary-encoder decoder: synchronises and deglitches raw

---
 rtl/quad_decoder.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/quad_decoder.sv
// Quadrature A/B encoder decoder: pin sync + deglitch, Gray phase tracking,
// signed x1/x2/x4 position count. Optional index pin under QDEC_INDEX_EN.
module quad_decoder #(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 4,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_in,
    input  logic                    b_in,
`ifdef QDEC_INDEX_EN
    input  logic                    idx_in,
    output logic                    idx_hit,
`endif
    input  logic                    en,
    input  logic                    clr,
    input  logic [1:0]              mode,
    output logic signed [CNT_W-1:0] count,
    output logic                    dir,
    output logic                    step,
    output logic                    err
);

`ifdef QDEC_INDEX_EN
    localparam int NP = 3;
`else
    localparam int NP = 2;
`endif

    localparam int RW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(FILT_LEN - 1);

    localparam int IW = $clog2(FILT_LEN + 3);
    localparam logic [IW-1:0] INIT_LAST = IW'(FILT_LEN + 2);

    localparam logic signed [CNT_W-1:0] MAXV = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] MINV = {1'b1, {(CNT_W-1){1'b0}}};

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    // Pin bundle: bit 1 = A, bit 0 = B, bit 2 = index when present
    logic [NP-1:0] pins;
    logic [NP-1:0] sync1;
    logic [NP-1:0] sync2;
    logic [NP-1:0] filt;
    logic [RW-1:0] run [NP];

`ifdef QDEC_INDEX_EN
    assign pins = {idx_in, a_in, b_in};
`else
    assign pins = {a_in, b_in};
`endif

    // Two-flop sync, then accept a new level only after FILT_LEN disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int i = 0; i < NP; i++) begin
                run[i] <= '0;
            end
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
            for (int i = 0; i < NP; i++) begin
                if (sync2[i] == filt[i]) begin
                    run[i] <= '0;
                end else if (run[i] == RUN_LAST) begin
                    filt[i] <= sync2[i];
                    run[i]  <= '0;
                end else begin
                    run[i] <= run[i] + RW'(1);
                end
            end
        end
    end

    state_t                  state;
    logic [IW-1:0]           init_cnt;
    logic [1:0]              ab;
    logic [1:0]              ab_q;
    logic                    chg_a;
    logic                    chg_b;
    logic                    is_cw;
    logic                    is_ccw;
    logic                    is_bad;
    logic                    sel;
    logic                    hit;
    logic                    idx_rise;
    logic signed [CNT_W-1:0] next_count;

    assign ab = filt[1:0];

    // Classify the filtered phase change and decide if this mode counts it
    always_comb begin
        chg_a  = ab[1] ^ ab_q[1];
        chg_b  = ab[0] ^ ab_q[0];
        is_bad = chg_a & chg_b;
        is_cw  = 1'b0;
        case ({ab_q, ab})
            4'b0010,
            4'b1011,
            4'b1101,
            4'b0100: is_cw = 1'b1;
            default: is_cw = 1'b0;
        endcase
        is_ccw = (chg_a ^ chg_b) & ~is_cw;
        sel    = 1'b1;
        unique case (mode)
            2'b00:        sel = 1'b1;
            2'b01:        sel = chg_a;
            2'b10, 2'b11: sel = (ab == 2'b00);
            default:      sel = 1'b1;
        endcase
        hit = (is_cw | is_ccw) & sel;
    end

    // Next counter value, wrapping or clamping at the signed limits
    always_comb begin
        next_count = count;
        if (is_cw) begin
            if (!(SATURATE != 0 && count == MAXV)) begin
                next_count = count + CNT_W'(1);
            end
        end else begin
            if (!(SATURATE != 0 && count == MINV)) begin
                next_count = count - CNT_W'(1);
            end
        end
    end

`ifdef QDEC_INDEX_EN
    logic idx_q;

    // Filtered index rising edge, only meaningful at phase 00 while running
    always_comb begin
        idx_rise = filt[2] & ~idx_q & (ab == 2'b00) & (state == S_RUN);
    end

    // Index edge tracker and one-cycle hit pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= 1'b0;
            idx_hit <= 1'b0;
        end else begin
            idx_q   <= filt[2];
            idx_hit <= idx_rise & ~clr;
        end
    end
`else
    always_comb begin
        idx_rise = 1'b0;
    end
`endif

    // Control FSM: settle the filters in INIT, then decode and count in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_INIT;
            init_cnt <= '0;
            ab_q     <= 2'b00;
            count    <= '0;
            dir      <= 1'b0;
            step     <= 1'b0;
            err      <= 1'b0;
        end else begin
            step <= 1'b0;
            unique case (state)
                S_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        ab_q  <= ab;
                        state <= S_RUN;
                    end else begin
                        init_cnt <= init_cnt + IW'(1);
                    end
                    if (clr) begin
                        count <= '0;
                        err   <= 1'b0;
                    end
                end
                S_RUN: begin
                    ab_q <= ab;
                    if (is_bad) begin
                        err <= 1'b1;
                    end
                    if (clr) begin
                        count <= '0;
                        err   <= 1'b0;
                    end else if (idx_rise) begin
                        count <= '0;
                    end else if (hit && en) begin
                        step  <= 1'b1;
                        dir   <= is_cw;
                        count <= next_count;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule
